// File: rtl/parking_lot_controller.sv
// -----------------------------------------------------------------------------
// parking_lot_controller
//
// Controls one entry gate and one exit gate over a lot of MAX_CAPACITY spaces.
// The entry lane runs a password FSM with bounded retries and a timed lockout.
// The exit lane runs an independent two-state FSM. Both gates are held open for
// GATE_CYCLES cycles per grant. A saturating occupancy counter tracks the lot
// and can be overwritten through an admin load port.
//
// Ports
//   clk              : system clock, rising edge
//   rstn             : asynchronous active-low reset
//   vehicle_at_entry : level, vehicle present at the entry lane
//   vehicle_at_exit  : level, vehicle present at the exit lane
//   pass_valid       : 1-cycle strobe, password attempt presented
//   pass_ok          : attempt correct, sampled only with pass_valid
//   load_en          : admin overwrite of occupancy this cycle
//   load_value       : admin occupancy value (saturated to MAX_CAPACITY)
//   entry_gate       : entry barrier open
//   exit_gate        : exit barrier open
//   entry_led        : red lamp, entry FSM in ERROR, LOCK or FULL
//   exit_led         : green lamp, mirrors exit_gate
//   state            : entry FSM state encoding
//   vehicle_count    : current occupancy
//   free_slots       : MAX_CAPACITY - vehicle_count
//   full / empty     : occupancy at capacity / at zero
//   locked           : entry FSM in LOCK
//
// Every output is driven straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module parking_lot_controller #(
  parameter int MAX_CAPACITY   = 100,
  parameter int CNT_W          = 8,
  parameter int GATE_CYCLES    = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vehicle_at_entry,
  input  logic             vehicle_at_exit,
  input  logic             pass_valid,
  input  logic             pass_ok,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_value,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             entry_led,
  output logic             exit_led,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] vehicle_count,
  output logic [CNT_W-1:0] free_slots,
  output logic             full,
  output logic             empty,
  output logic             locked
);

  // Entry FSM encoding (visible on the state port)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ERROR = 3'd2;
  localparam logic [2:0] S_OPEN  = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;
  localparam logic [2:0] S_FULL  = 3'd5;

  // Exit FSM encoding
  localparam logic X_IDLE = 1'b0;
  localparam logic X_OPEN = 1'b1;

  // Timers count down from N-1 to 0, so they only need to hold N-1.
  localparam int GT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int LT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int TR_W = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CAPACITY);
  localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [GT_W-1:0]  GATE_LOAD = GT_W'(GATE_CYCLES - 1);
  localparam logic [GT_W-1:0]  GT_ZERO   = {GT_W{1'b0}};
  localparam logic [GT_W-1:0]  GT_ONE    = GT_W'(1);
  localparam logic [LT_W-1:0]  LOCK_LOAD = LT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [LT_W-1:0]  LT_ZERO   = {LT_W{1'b0}};
  localparam logic [LT_W-1:0]  LT_ONE    = LT_W'(1);
  localparam logic [TR_W-1:0]  TRY_LAST  = TR_W'(MAX_TRIES - 1);
  localparam logic [TR_W-1:0]  TR_ZERO   = {TR_W{1'b0}};
  localparam logic [TR_W-1:0]  TR_ONE    = TR_W'(1);

  logic [2:0]       state_r, state_nxt_s;
  logic             x_state_r, x_state_nxt_s;
  logic [GT_W-1:0]  gate_tmr_r, gate_tmr_nxt_s;
  logic [GT_W-1:0]  x_tmr_r, x_tmr_nxt_s;
  logic [LT_W-1:0]  lock_tmr_r, lock_tmr_nxt_s;
  logic [TR_W-1:0]  tries_r, tries_nxt_s;
  logic             inc_s, dec_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [CNT_W-1:0] free_r;
  logic             full_r, empty_r;
  logic             entry_gate_r, exit_gate_r, entry_led_r, locked_r;

  // Entry FSM next-state, retry counter, gate and lockout timers
  always_comb begin
    state_nxt_s    = state_r;
    gate_tmr_nxt_s = gate_tmr_r;
    lock_tmr_nxt_s = lock_tmr_r;
    tries_nxt_s    = tries_r;
    inc_s          = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (vehicle_at_entry) begin
          state_nxt_s = full_r ? S_FULL : S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        // A password attempt outranks the vehicle leaving in the same cycle.
        if (pass_valid) begin
          if (pass_ok) begin
            if (!full_r) begin
              state_nxt_s    = S_OPEN;
              inc_s          = 1'b1;
              tries_nxt_s    = TR_ZERO;
              gate_tmr_nxt_s = GATE_LOAD;
            end else begin
              state_nxt_s = S_FULL;
            end
          end else begin
            tries_nxt_s = tries_r + TR_ONE;
            if (tries_r == TRY_LAST) begin
              state_nxt_s    = S_LOCK;
              lock_tmr_nxt_s = LOCK_LOAD;
            end else begin
              state_nxt_s = S_ERROR;
            end
          end
        end else if (!vehicle_at_entry) begin
          state_nxt_s = S_IDLE;
          tries_nxt_s = TR_ZERO;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_ERROR: begin
        state_nxt_s = S_WAIT;
      end
      S_OPEN: begin
        if (gate_tmr_r == GT_ZERO) begin
          state_nxt_s = S_IDLE;
        end else begin
          gate_tmr_nxt_s = gate_tmr_r - GT_ONE;
        end
      end
      S_LOCK: begin
        if (lock_tmr_r == LT_ZERO) begin
          state_nxt_s = S_IDLE;
          tries_nxt_s = TR_ZERO;
        end else begin
          lock_tmr_nxt_s = lock_tmr_r - LT_ONE;
        end
      end
      S_FULL: begin
        if (!vehicle_at_entry) begin
          state_nxt_s = S_IDLE;
        end else if (!full_r) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_FULL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        tries_nxt_s = TR_ZERO;
      end
    endcase
  end

  // Exit FSM next-state and exit gate timer; an exit request on an empty lot is ignored
  always_comb begin
    x_state_nxt_s = x_state_r;
    x_tmr_nxt_s   = x_tmr_r;
    dec_s         = 1'b0;
    case (x_state_r)
      X_IDLE: begin
        if (vehicle_at_exit && !empty_r) begin
          x_state_nxt_s = X_OPEN;
          x_tmr_nxt_s   = GATE_LOAD;
          dec_s         = 1'b1;
        end else begin
          x_state_nxt_s = X_IDLE;
        end
      end
      X_OPEN: begin
        if (x_tmr_r == GT_ZERO) begin
          x_state_nxt_s = X_IDLE;
        end else begin
          x_tmr_nxt_s = x_tmr_r - GT_ONE;
        end
      end
      default: begin
        x_state_nxt_s = X_IDLE;
      end
    endcase
  end

  // Occupancy next value: admin load first, then a lone inc or dec; both cancel
  always_comb begin
    count_nxt_s = count_r;
    if (load_en) begin
      count_nxt_s = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end else if (inc_s && !dec_s) begin
      count_nxt_s = (count_r < MAX_CNT) ? (count_r + ONE_CNT) : count_r;
    end else if (dec_s && !inc_s) begin
      count_nxt_s = (count_r != ZERO_CNT) ? (count_r - ONE_CNT) : count_r;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State, timers, counter and all output flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      x_state_r    <= X_IDLE;
      gate_tmr_r   <= GT_ZERO;
      x_tmr_r      <= GT_ZERO;
      lock_tmr_r   <= LT_ZERO;
      tries_r      <= TR_ZERO;
      count_r      <= ZERO_CNT;
      free_r       <= MAX_CNT;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      entry_gate_r <= 1'b0;
      exit_gate_r  <= 1'b0;
      entry_led_r  <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      x_state_r    <= x_state_nxt_s;
      gate_tmr_r   <= gate_tmr_nxt_s;
      x_tmr_r      <= x_tmr_nxt_s;
      lock_tmr_r   <= lock_tmr_nxt_s;
      tries_r      <= tries_nxt_s;
      count_r      <= count_nxt_s;
      // Status flags derive from the same next value so they never lag the count.
      free_r       <= MAX_CNT - count_nxt_s;
      full_r       <= (count_nxt_s == MAX_CNT);
      empty_r      <= (count_nxt_s == ZERO_CNT);
      entry_gate_r <= (state_nxt_s == S_OPEN);
      exit_gate_r  <= (x_state_nxt_s == X_OPEN);
      entry_led_r  <= (state_nxt_s == S_ERROR) || (state_nxt_s == S_LOCK) ||
                      (state_nxt_s == S_FULL);
      locked_r     <= (state_nxt_s == S_LOCK);
    end
  end

  assign state         = state_r;
  assign vehicle_count = count_r;
  assign free_slots    = free_r;
  assign full          = full_r;
  assign empty         = empty_r;
  assign entry_gate    = entry_gate_r;
  assign exit_gate     = exit_gate_r;
  assign exit_led      = exit_gate_r;
  assign entry_led     = entry_led_r;
  assign locked        = locked_r;

endmodule
